// File: rtl/seg7_scan_nx_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: mode encodings,
// segment bit positions and the hex font.
package seg7_pkg;

  typedef enum logic [1:0] {
    SEG7_HEX     = 2'd0,
    SEG7_DIRECT  = 2'd1,
    SEG7_HEX_LZB = 2'd2,
    SEG7_BLANK   = 2'd3
  } seg7_mode_e;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Glyphs 0-9, A, b, C, d, E, F with bit0 = segment a.
  localparam logic [6:0] SEG7_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_scan_nx_if.sv
// Display-data inputs and scan outputs of the 7-segment scanner, bundled
// so the board top can hand one port to the driver.
interface seg7_scan_nx_if #(
  parameter int DIGITS   = 4,
  parameter int PWM_BITS = 4
);
  logic [4*DIGITS-1:0] di;
  logic [8*DIGITS-1:0] pixels;
  logic [DIGITS-1:0]   dp;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] brightness;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic [2:0]          digit;
  logic                frame;

  modport master (
    output di, pixels, dp, mode, brightness,
    input  seg, an, digit, frame
  );

  modport slave (
    input  di, pixels, dp, mode, brightness,
    output seg, an, digit, frame
  );
endinterface

// File: rtl/seg7_scan_nx_hex_font.sv
// Combinational nibble to 7-segment decoder (bit0 = a, active-high).
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG7_FONT[nibble];

endmodule

// File: rtl/seg7_scan_nx.sv
// Multiplexed 7-segment scanner with per-frame data latch, four display
// modes, leading-zero blanking, PWM brightness and a dead cycle per slot.
module seg7_scan_nx
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIV      = 250,
  parameter int PWM_BITS = 4
) (
  input logic            clk,
  input logic            reset,
  seg7_scan_nx_if.slave  bus
);

  localparam int PW = $clog2(DIV);
  localparam int TW = $clog2(DIV + 1);
  localparam int MW = PWM_BITS + TW;

  logic [PW-1:0]       pre;
  logic [2:0]          cur;
  logic                slot_end;
  logic                frame_end;

  logic [4*DIGITS-1:0] di_l;
  logic [8*DIGITS-1:0] pixels_l;
  logic [DIGITS-1:0]   dp_l;
  seg7_mode_e          mode_l;
  logic [TW-1:0]       thr;
  logic [MW-1:0]       thr_prod;
  logic [TW-1:0]       thr_next;

  logic [DIGITS-1:0]   lzb_mask;
  logic                zero_above;
  logic [3:0]          nib;
  logic [7:0]          pix;
  logic                dp_bit;
  logic                lead_zero;
  logic [6:0]          font_seg;
  logic                lit;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  assign slot_end  = (pre == PW'(DIV - 1));
  assign frame_end = slot_end && (cur == 3'(DIGITS - 1));

  // Full-scale brightness gives thr = DIV, keeping the slot lit after the dead cycle.
  assign thr_prod = (MW'(bus.brightness) + MW'(1)) * MW'(DIV);
  assign thr_next = TW'(thr_prod >> PWM_BITS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      cur <= '0;
    end else if (slot_end) begin
      pre <= '0;
      cur <= (cur == 3'(DIGITS - 1)) ? 3'd0 : cur + 3'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      di_l     <= '0;
      pixels_l <= '0;
      dp_l     <= '0;
      mode_l   <= SEG7_BLANK;
      thr      <= '0;
    end else if (frame_end) begin
      di_l     <= bus.di;
      pixels_l <= bus.pixels;
      dp_l     <= bus.dp;
      mode_l   <= seg7_mode_e'(bus.mode);
      thr      <= thr_next;
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are 0.
  always_comb begin
    lzb_mask   = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above  = zero_above && (di_l[4*k +: 4] == 4'h0);
      lzb_mask[k] = zero_above && (k != 0);
    end
  end

  always_comb begin
    nib       = '0;
    pix       = '0;
    dp_bit    = 1'b0;
    lead_zero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (cur == 3'(k)) begin
        nib       = di_l[4*k +: 4];
        pix       = pixels_l[8*k +: 8];
        dp_bit    = dp_l[k];
        lead_zero = lzb_mask[k];
      end
    end
  end

  seg7_hex_font u_font (
    .nibble (nib),
    .seg    (font_seg)
  );

  always_comb begin
    seg_next = '0;
    an_next  = '0;
    lit      = (pre != '0) && (TW'(pre) < thr) && (mode_l != SEG7_BLANK);
    case (mode_l)
      SEG7_HEX: begin
        seg_next[6:0]  = font_seg;
        seg_next[SEG_DP] = dp_bit;
      end
      SEG7_HEX_LZB: begin
        seg_next[6:0]  = lead_zero ? 7'h00 : font_seg;
        seg_next[SEG_DP] = dp_bit;
      end
      SEG7_DIRECT: seg_next = pix;
      default:     seg_next = '0;
    endcase
    for (int k = 0; k < DIGITS; k++) begin
      if (cur == 3'(k)) an_next[k] = lit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.seg   <= '0;
      bus.an    <= '0;
      bus.frame <= 1'b0;
      bus.digit <= '0;
    end else begin
      bus.seg   <= seg_next;
      bus.an    <= an_next;
      bus.frame <= frame_end;
      bus.digit <= cur;
    end
  end

endmodule

// File: tb/tb_seg7_scan_nx.sv
// Directed, table-driven bench for seg7_scan_nx at DIGITS=4, DIV=8, PWM_BITS=4.
module tb_seg7_scan_nx;

  localparam int DIGITS   = 4;
  localparam int DIV      = 8;
  localparam int PWM_BITS = 4;
  localparam int FRAME    = DIGITS * DIV;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  seg7_scan_nx_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) bus ();

  seg7_scan_nx #(.DIGITS(DIGITS), .DIV(DIV), .PWM_BITS(PWM_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] di;
    logic [31:0] pixels;
    logic [3:0]  dp;
    logic [3:0]  brightness;
    logic [31:0] exp_seg;
    logic [7:0]  exp_an;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.mode       = v.mode;
    bus.di         = v.di;
    bus.pixels     = v.pixels;
    bus.dp         = v.dp;
    bus.brightness = v.brightness;
  endtask

  task automatic waitFrame(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame !== 1'b1 && n < 3 * FRAME);
    if (bus.frame !== 1'b1) checkOutput({name, " frame timeout"}, 32'(n), 32'(FRAME));
  endtask

  // Counts cycles up to the next frame pulse while requiring every enable to stay low.
  task automatic darkFrame(input string name);
    int n   = 0;
    int lit = 0;
    do begin
      tick();
      n++;
      if (bus.an !== '0) lit++;
    end while (bus.frame !== 1'b1 && n < 3 * FRAME);
    checkOutput({name, " cycles to frame"}, 32'(n), 32'(FRAME));
    checkOutput({name, " lit samples"}, 32'(lit), 32'd0);
  endtask

  // Must be entered on the sample that showed a frame pulse.
  task automatic scanFrame(input string name, input logic [31:0] exp_seg,
                           input logic [7:0] exp_an);
    logic [7:0] an_bits;
    logic [3:0] stray = '0;
    int         frames = 0;
    for (int slot = 0; slot < DIGITS; slot++) begin
      an_bits = '0;
      for (int p = 0; p < DIV; p++) begin
        tick();
        an_bits[p] = bus.an[slot];
        stray      = stray | (bus.an & ~4'(1 << slot));
        if (bus.frame === 1'b1) frames++;
        if (p == 1) begin
          checkOutput($sformatf("%s seg d%0d", name, slot), 32'(bus.seg),
                      32'(exp_seg[8*slot +: 8]));
          checkOutput($sformatf("%s digit d%0d", name, slot), 32'(bus.digit), 32'(slot));
        end
      end
      checkOutput($sformatf("%s an pattern d%0d", name, slot), 32'(an_bits), 32'(exp_an));
    end
    checkOutput({name, " stray an"}, 32'(stray), 32'd0);
    checkOutput({name, " frame pulses/last"}, {31'(frames), bus.frame}, {31'd1, 1'b1});
  endtask

  initial begin
    vecs[0] = '{2'd0, 16'h12AF, 32'h0,        4'h0, 4'hF, 32'h065B7771, 8'hFE};
    vecs[1] = '{2'd2, 16'h0030, 32'h0,        4'h0, 4'hF, 32'h00004F3F, 8'hFE};
    vecs[2] = '{2'd2, 16'h0000, 32'h0,        4'h0, 4'hF, 32'h0000003F, 8'hFE};
    vecs[3] = '{2'd1, 16'h1234, 32'h80FF0001, 4'hF, 4'hF, 32'h80FF0001, 8'hFE};
    vecs[4] = '{2'd0, 16'h12AF, 32'h0,        4'h0, 4'h3, 32'h065B7771, 8'h02};
    vecs[5] = '{2'd0, 16'h12AF, 32'h0,        4'h0, 4'h0, 32'h065B7771, 8'h00};
    vecs[6] = '{2'd3, 16'h12AF, 32'hFFFFFFFF, 4'hF, 4'hF, 32'h00000000, 8'h00};
    vecs[7] = '{2'd0, 16'h0123, 32'h0,        4'h5, 4'hF, 32'h3F865BCF, 8'hFE};
    vecs[8] = '{2'd2, 16'h0103, 32'h0,        4'h8, 4'hF, 32'h80063F4F, 8'hFE};

    bus.mode = 2'd0;
    bus.di = 16'h0;
    bus.pixels = 32'h0;
    bus.dp = 4'h0;
    bus.brightness = 4'hF;

    repeat (3) tick();
    checkOutput("reset seg", 32'(bus.seg), 32'd0);
    checkOutput("reset an", 32'(bus.an), 32'd0);
    checkOutput("reset digit", 32'(bus.digit), 32'd0);
    checkOutput("reset frame", 32'(bus.frame), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    darkFrame("startup");

    for (int i = 0; i < 9; i++) begin
      $display("[TB] vector %0d mode=%0d di=%h", i, vecs[i].mode, vecs[i].di);
      applyStimulus(vecs[i]);
      waitFrame($sformatf("vec%0d", i));
      scanFrame($sformatf("vec%0d", i), vecs[i].exp_seg, vecs[i].exp_an);
    end

    // Mid-frame data change stays hidden until the next frame latch.
    begin
      int n = 0;
      int early = 0;
      applyStimulus('{2'd0, 16'h1111, 32'h0, 4'h0, 4'hF, 32'h0, 8'h0});
      waitFrame("tear setup");
      repeat (10) tick();
      bus.di = 16'h2222;
      do begin
        tick();
        n++;
        if (bus.seg === 8'h5B) early++;
      end while (bus.frame !== 1'b1 && n < 3 * FRAME);
      checkOutput("tear early 5B samples", 32'(early), 32'd0);
      checkOutput("tear cycles to frame", 32'(n), 32'(FRAME - 10));
      scanFrame("tear next", 32'h5B5B5B5B, 8'hFE);
    end

    // Asynchronous reset mid-slot, then one dark frame before resuming.
    repeat (3) tick();
    checkOutput("pre-reset an", 32'(bus.an), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset seg", 32'(bus.seg), 32'd0);
    checkOutput("async reset an", 32'(bus.an), 32'd0);
    checkOutput("async reset digit", 32'(bus.digit), 32'd0);
    checkOutput("async reset frame", 32'(bus.frame), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    darkFrame("post reset");
    scanFrame("resume", 32'h5B5B5B5B, 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_nx.md
# seg7_scan_nx

Parametrised multiplexed 7-segment display driver for the board top. It scans `DIGITS` common-anode/cathode positions from one clock and latches display data once per frame so digits never tear. It adds four display modes (hex, direct pixels, hex with leading-zero blanking, blank), per-digit decimal points, PWM brightness and an anti-ghosting dead cycle. Outputs are active-high; the board top inverts them for the pins.

## Interface
- `DIGITS`, 4: number of digit positions, 1..8.
- `DIV`, 250: clk cycles per digit slot, ≥ 4 (1 MHz clk → 1 kHz frame at 4 digits).
- `PWM_BITS`, 4: brightness resolution.
- `clk` in 1: single clock (board drives 1 MHz).
- `reset` in 1: asynchronous, active-low.
- `di` in 4*DIGITS: hex nibbles; nibble k shown on digit k (digit 0 = rightmost).
- `pixels` in 8*DIGITS: direct segment bytes, byte k → digit k.
- `dp` in DIGITS: decimal point per digit (hex modes only).
- `mode` in 2: 0 hex, 1 direct, 2 hex + leading-zero blank, 3 blank.
- `brightness` in PWM_BITS: duty level, max value = full on.
- `seg` out 8: bit0..6 = a..g, bit7 = dp, active-high.
- `an` out DIGITS: one-hot digit enable, active-high.
- `digit` out 3: index of current slot.
- `frame` out 1: one-cycle pulse on the last cycle of digit DIGITS-1.

## Operation
- Prescaler `pre` counts 0..DIV-1; on wrap, `digit` advances, wrapping DIGITS-1 → 0.
- Frame latch: in the cycle when `pre`=DIV-1 and `digit`=DIGITS-1 (same cycle as `frame`), `di`, `pixels`, `dp`, `mode`, and threshold `thr` = ((brightness+1)*DIV) >> PWM_BITS are captured. Input changes elsewhere in the frame are not visible until the next frame.
- Enable window: `an[digit]` is asserted while 1 ≤ `pre` < `thr`. `pre`=0 is always a dead cycle (anti-ghosting). If `thr` ≤ 1, the digit stays dark.
- Segment value per latched mode:
  - Hex: font(nibble) | dp<<7.
  - Direct: pixel byte unchanged.
  - Blank: 0, with `an` held at 0.
- Mode 2: digit k ≥ 1 shows font bits 0 while nibble k and all higher nibbles are 0. The dp bit is still shown. Digit 0 is never blanked.
- Font: 0→3F 1→06 2→5B 3→4F 4→66 5→6D 6→7D 7→07 8→7F 9→6F A→77 b→7C C→39 d→5E E→79 F→71.

## Timing
- `seg`, `an`, `frame` and `digit` are registered.
- `seg`/`an` reflect `pre`/`digit` from the previous cycle, giving 1-cycle latency.
- Reset values:
  - `seg`=0, `an`=0, `frame`=0, `digit`=0, `pre`=0.
  - Latched data = 0, latched mode = 3 (blank), `thr`=0.
  - Display is dark until the first frame latch, DIGITS*DIV cycles after reset release.
- Reset asserted mid-frame forces all outputs to reset values in the same instant (asynchronous).
- Frame period = DIGITS*DIV cycles exactly; `frame` pulses once per period.
- `thr` width is ceil(log2(DIV+1)) bits; the product uses PWM_BITS+that width, so there is no overflow.

## Structure
- Package `seg7_pkg`:
  - mode encodings (`SEG7_HEX`, `SEG7_DIRECT`, `SEG7_HEX_LZB`, `SEG7_BLANK`).
  - 16-entry font constant.
  - segment bit-position constants.
- Sub-module `seg7_hex_font`: combinational nibble → 7-bit segment decoder, instantiated once on the current-digit nibble.
- Top: prescaler, digit counter, frame latch, LZB mask computation (combinational on latched `di`), PWM compare, output registers.

## Test plan
- DIGITS=4, DIV=8, brightness=15, mode=0, di=0x12AF, dp=0.
  - Second frame shows seg 71, 77, 5B, 06 on digits 0..3.
  - Each `an` is high for pre 1..7, low at pre 0.
  - `frame` pulses every 32 cycles.
- mode=2, di=0x0030.
  - Digits 3 and 2 seg=00 with `an` still pulsing; digit 1=4F, digit 0=3F.
  - di=0x0000 → only digit 0 shows 3F.
- mode=1, pixels=0x80FF0001.
  - Digits 0..3 show 01, 00, FF, 80.
  - dp input has no effect.
- brightness=3, DIV=8: thr=2, so `an` is high only at pre=1 (1 cycle per slot). brightness=0: thr=0, always dark.
- Change di from 0x1111 to 0x2222 mid-frame → no digit shows 5B before the next `frame` pulse; all four show 5B in the following frame.
- Assert reset low mid-slot → `seg`/`an` immediately 0. After release, outputs stay dark for 32 cycles, then resume normally.
